// File: rtl/hazard_unit_fwd.sv
// Decode-side RAW hazard unit. It tracks in-flight writers across STAGES slots and
// resolves each dependency by forwarding or by stall plus bubble. It also handles flushes and freezes.

module hazard_slot_match #(
  parameter int NREG = 32,
  parameter int RAW  = 5
) (
  input  logic            vld,
  input  logic            we,
  input  logic [RAW-1:0]  rd,
  input  logic [1:0]      rd_en,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  output logic            hit1,
  output logic            hit2,
  output logic [NREG-1:0] busy
);
  logic wr;
  assign wr   = vld & we & (rd != '0);
  assign hit1 = wr & rd_en[0] & (rs1 == rd);
  assign hit2 = wr & rd_en[1] & (rs2 == rd);

  always_comb begin
    busy     = '0;
    busy[rd] = wr;
  end
endmodule

module hazard_unit_fwd #(
  parameter int NREG       = 32,
  parameter int RAW        = 5,
  parameter int STAGES     = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  localparam int SW        = $clog2(STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_rd_en,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_we,
  input  logic [RAW-1:0]   id_rd,
  input  logic             id_is_load,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_WB,
  output logic             flush_D,
  output logic             flush_E,
  output logic [SW-1:0]    fwd_sel_rs1,
  output logic [SW-1:0]    fwd_sel_rs2,
  output logic [NREG-1:0]  busy_regs,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic           vld;
    logic           we;
    logic [RAW-1:0] rd;
    logic           ld;
  } slot_t;

  slot_t [STAGES-1:0]           slot_q;
  logic  [STAGES-1:0]           hit1, hit2;
  logic  [STAGES-1:0][NREG-1:0] busy_s;
  logic  [SW-1:0]               i1, i2;
  logic                         h1, h2, hz, stall_all, rdr_go, hz_go;

  // Slot valids are masked by reset so everything reads as cleared while reset is low
  for (genvar s = 0; s < STAGES; s++) begin : g_slot
    hazard_slot_match #(.NREG(NREG), .RAW(RAW)) u_match (
      .vld(slot_q[s].vld & reset), .we(slot_q[s].we), .rd(slot_q[s].rd),
      .rd_en(id_rd_en), .rs1(id_rs1), .rs2(id_rs2),
      .hit1(hit1[s]), .hit2(hit2[s]), .busy(busy_s[s])
    );
  end

  // Scan oldest to youngest so the lowest-index match wins
  always_comb begin
    i1 = '0; i2 = '0; h1 = 1'b0; h2 = 1'b0;
    for (int s = STAGES-1; s >= 0; s--) begin
      if (hit1[s]) begin
        i1 = SW'(s+1);
        h1 = (FWD_EN != 0) ? (slot_q[s].ld && s < LOAD_STAGE) : (s < STAGES-1);
      end
      if (hit2[s]) begin
        i2 = SW'(s+1);
        h2 = (FWD_EN != 0) ? (slot_q[s].ld && s < LOAD_STAGE) : (s < STAGES-1);
      end
    end
  end

  always_comb begin
    busy_regs = '0;
    for (int s = 0; s < STAGES; s++) busy_regs = busy_regs | busy_s[s];
  end

  assign fwd_sel_rs1 = (FWD_EN != 0) ? i1 : '0;
  assign fwd_sel_rs2 = (FWD_EN != 0) ? i2 : '0;

  assign hz        = id_valid & (h1 | h2);
  assign stall_all = reset & mem_busy;
  assign rdr_go    = reset & ~mem_busy & redirect;
  assign hz_go     = reset & ~mem_busy & ~redirect & hz;

  assign stall_F  = stall_all | hz_go;
  assign stall_D  = stall_all | hz_go;
  assign stall_E  = stall_all;
  assign stall_M  = stall_all;
  assign stall_WB = stall_all;
  assign flush_D  = rdr_go;
  assign flush_E  = rdr_go | hz_go;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) slot_q[s].vld <= 1'b0;
      stall_cnt <= '0;
    end else if (!mem_busy) begin
      for (int s = 1; s < STAGES; s++) slot_q[s] <= slot_q[s-1];
      if (redirect || hz)
        slot_q[0] <= '0;
      else
        slot_q[0] <= '{vld: id_valid, we: id_we & (id_rd != '0), rd: id_rd, ld: id_is_load};
      if (!redirect && hz && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit_fwd.sv
// Directed bench for hazard_unit_fwd: stall-only, bypass, and narrow-counter instances share one stimulus.

module tb_hazard_unit_fwd;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_we, id_is_load, redirect, mem_busy;
  logic [1:0] id_rd_en;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [2:0]       sF, sD, sE, sM, sW, fD, fE;
  logic [2:0][1:0]  f1, f2;
  logic [2:0][31:0] bz;
  logic [15:0]      cnt0, cnt1;
  logic [1:0]       cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit_fwd #(.FWD_EN(0)) u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy),
    .stall_F(sF[0]), .stall_D(sD[0]), .stall_E(sE[0]), .stall_M(sM[0]), .stall_WB(sW[0]),
    .flush_D(fD[0]), .flush_E(fE[0]), .fwd_sel_rs1(f1[0]), .fwd_sel_rs2(f2[0]),
    .busy_regs(bz[0]), .stall_cnt(cnt0));

  hazard_unit_fwd #(.FWD_EN(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy),
    .stall_F(sF[1]), .stall_D(sD[1]), .stall_E(sE[1]), .stall_M(sM[1]), .stall_WB(sW[1]),
    .flush_D(fD[1]), .flush_E(fE[1]), .fwd_sel_rs1(f1[1]), .fwd_sel_rs2(f2[1]),
    .busy_regs(bz[1]), .stall_cnt(cnt1));

  hazard_unit_fwd #(.FWD_EN(0), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy),
    .stall_F(sF[2]), .stall_D(sD[2]), .stall_E(sE[2]), .stall_M(sM[2]), .stall_WB(sW[2]),
    .flush_D(fD[2]), .flush_E(fE[2]), .fwd_sel_rs1(f1[2]), .fwd_sel_rs2(f2[2]),
    .busy_regs(bz[2]), .stall_cnt(cnt2));

  typedef struct {
    string      nm;
    logic       v, w;
    logic [4:0] rd;
    logic       ld;
    logic [1:0] en;
    logic [4:0] r1, r2;
    logic       rdr, mb;
    logic [4:0] st;   // {F,D,E,M,WB}
    logic [1:0] fl;   // {D,E}
    logic       fc;   // fwd_sel meaningful
    logic [1:0] e1, e2;
    logic [31:0] busy;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(string nm, logic v, logic w, logic [4:0] rd, logic ld,
                              logic [1:0] en, logic [4:0] r1, logic [4:0] r2, logic rdr,
                              logic mb, logic [4:0] st, logic [1:0] fl, logic fc,
                              logic [1:0] e1, logic [1:0] e2, logic [31:0] busy,
                              logic [15:0] cnt);
    vec_t t;
    t.nm = nm; t.v = v; t.w = w; t.rd = rd; t.ld = ld; t.en = en; t.r1 = r1; t.r2 = r2;
    t.rdr = rdr; t.mb = mb; t.st = st; t.fl = fl; t.fc = fc; t.e1 = e1; t.e2 = e2;
    t.busy = busy; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] stv(int i);
    return {sF[i], sD[i], sE[i], sM[i], sW[i]};
  endfunction

  function automatic logic [1:0] flv(int i);
    return {fD[i], fE[i]};
  endfunction

  // One cycle: drive at negedge, outputs settle, caller checks before the next posedge
  task automatic put(logic v, logic w, logic [4:0] rd, logic ld, logic [1:0] en,
                     logic [4:0] r1, logic [4:0] r2, logic rdr, logic mb);
    @(negedge clk);
    id_valid = v; id_we = w; id_rd = rd; id_is_load = ld; id_rd_en = en;
    id_rs1 = r1; id_rs2 = r2; redirect = rdr; mem_busy = mb;
    #1;
  endtask

  task automatic idle();
    put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  vec_t tbl[19];

  initial begin
    reset = 1'b0;
    id_valid = 0; id_we = 0; id_rd = 0; id_is_load = 0; id_rd_en = 0;
    id_rs1 = 0; id_rs2 = 0; redirect = 0; mem_busy = 0;
    idle(); idle();
    @(negedge clk);
    reset = 1'b1;

    //            name        v  w  rd ld en    r1 r2 rdr mb st        fl     fc e1 e2 busy        cnt
    tbl[0]  = mk("alu_x5",    1, 1, 5, 0, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h0,     0);
    tbl[1]  = mk("fwd_e",     1, 0, 0, 0, 2'b01, 5, 0, 0, 0, 5'b00000, 2'b00, 1, 1, 0, 32'h20,    0);
    tbl[2]  = mk("alu_x6",    1, 1, 6, 0, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h20,    0);
    tbl[3]  = mk("fwd_two",   1, 0, 0, 0, 2'b11, 5, 6, 0, 0, 5'b00000, 2'b00, 1, 3, 1, 32'h60,    0);
    tbl[4]  = mk("load_x7",   1, 1, 7, 1, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h40,    0);
    tbl[5]  = mk("ld_use",    1, 0, 0, 0, 2'b10, 0, 7, 0, 0, 5'b11000, 2'b01, 0, 0, 0, 32'hC0,    0);
    tbl[6]  = mk("ld_fwd",    1, 0, 0, 0, 2'b10, 0, 7, 0, 0, 5'b00000, 2'b00, 1, 0, 2, 32'h80,    1);
    tbl[7]  = mk("ld_last",   0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h80,    1);
    tbl[8]  = mk("alu_x0",    1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h0,     1);
    tbl[9]  = mk("rd_x0",     1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h0,     1);
    tbl[10] = mk("load_x9",   1, 1, 9, 1, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h0,     1);
    tbl[11] = mk("redir_hz",  1, 0, 0, 0, 2'b01, 9, 0, 1, 0, 5'b00000, 2'b11, 0, 0, 0, 32'h200,   1);
    tbl[12] = mk("post_redir",0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h200,   1);
    tbl[13] = mk("load_x10",  1, 1, 10,1, 2'b00, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0, 0, 32'h200,   1);
    tbl[14] = mk("mb_hz",     1, 0, 0, 0, 2'b10, 0, 10,0, 1, 5'b11111, 2'b00, 0, 0, 0, 32'h400,   1);
    tbl[15] = mk("mb_redir",  1, 0, 0, 0, 2'b10, 0, 10,1, 1, 5'b11111, 2'b00, 0, 0, 0, 32'h400,   1);
    tbl[16] = mk("mb_hold",   1, 0, 0, 0, 2'b10, 0, 10,0, 1, 5'b11111, 2'b00, 0, 0, 0, 32'h400,   1);
    tbl[17] = mk("hz_resume", 1, 0, 0, 0, 2'b10, 0, 10,0, 0, 5'b11000, 2'b01, 0, 0, 0, 32'h400,   1);
    tbl[18] = mk("ld_fwd2",   1, 0, 0, 0, 2'b10, 0, 10,0, 0, 5'b00000, 2'b00, 1, 0, 2, 32'h400,   2);

    for (int i = 0; i < 19; i++) begin
      put(tbl[i].v, tbl[i].w, tbl[i].rd, tbl[i].ld, tbl[i].en, tbl[i].r1, tbl[i].r2,
          tbl[i].rdr, tbl[i].mb);
      chk({tbl[i].nm, ".stall"}, 32'(stv(1)), 32'(tbl[i].st));
      chk({tbl[i].nm, ".flush"}, 32'(flv(1)), 32'(tbl[i].fl));
      chk({tbl[i].nm, ".busy"},  bz[1], tbl[i].busy);
      chk({tbl[i].nm, ".cnt"},   32'(cnt1), 32'(tbl[i].cnt));
      if (tbl[i].fc) begin
        chk({tbl[i].nm, ".fwd1"}, 32'(f1[1]), 32'(tbl[i].e1));
        chk({tbl[i].nm, ".fwd2"}, 32'(f2[1]), 32'(tbl[i].e2));
      end
    end

    // Build stall_cnt up to 9 with load-use pairs, then fill all three slots
    for (int k = 0; k < 7; k++) begin
      put(1, 1, 3, 1, 2'b00, 0, 0, 0, 0);
      put(1, 0, 0, 0, 2'b01, 3, 0, 0, 0);
      put(1, 0, 0, 0, 2'b01, 3, 0, 0, 0);
    end
    put(1, 1, 11, 0, 2'b00, 0, 0, 0, 0);
    put(1, 1, 12, 0, 2'b00, 0, 0, 0, 0);
    put(1, 1, 13, 0, 2'b00, 0, 0, 0, 0);
    idle();
    chk("pre_rst.cnt",  32'(cnt1), 32'd9);
    chk("pre_rst.busy", bz[1], 32'h3800);

    // Reset low: outputs read as cleared even with mem_busy high and a dependent read
    @(negedge clk);
    reset = 1'b0;
    put(1, 0, 0, 0, 2'b01, 13, 0, 0, 1);
    chk("in_rst.stall", 32'(stv(1)), 32'd0);
    chk("in_rst.flush", 32'(flv(1)), 32'd0);
    chk("in_rst.busy",  bz[1], 32'd0);
    chk("in_rst.fwd1",  32'(f1[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    chk("post_rst.cnt",   32'(cnt1), 32'd0);
    chk("post_rst.busy",  bz[1], 32'd0);
    chk("post_rst.stall", 32'(stv(1)), 32'd0);
    chk("post_rst.flush", 32'(flv(1)), 32'd0);
    chk("post_rst.cnt0",  32'(cnt0), 32'd0);

    // ALU producer then consumer: u0 stalls twice, u1 bypasses from E, then M, then WB
    put(1, 1, 5, 0, 2'b00, 0, 0, 0, 0);
    chk("s0_a.stall", 32'(stv(0)), 32'd0);
    put(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    chk("s0_b.stall", 32'(stv(0)), 32'b11000);
    chk("s0_b.flush", 32'(flv(0)), 32'b01);
    chk("s1_b.stall", 32'(stv(1)), 32'd0);
    chk("s1_b.fwd1",  32'(f1[1]), 32'd1);
    put(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    chk("s0_c.stall", 32'(stv(0)), 32'b11000);
    chk("s0_c.cnt",   32'(cnt0), 32'd1);
    chk("s1_c.fwd1",  32'(f1[1]), 32'd2);
    put(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    chk("s0_d.stall", 32'(stv(0)), 32'd0);
    chk("s0_d.flush", 32'(flv(0)), 32'd0);
    chk("s0_d.fwd1",  32'(f1[0]), 32'd0);
    chk("s0_d.busy",  bz[0], 32'h20);
    chk("s0_d.cnt",   32'(cnt0), 32'd2);
    chk("s1_d.fwd1",  32'(f1[1]), 32'd3);

    // Second stall pair: 16-bit counter reaches 4, 2-bit counter pins at 3
    put(1, 1, 6, 0, 2'b00, 0, 0, 0, 0);
    chk("sat_a.cnt2", 32'(cnt2), 32'd2);
    put(1, 0, 0, 0, 2'b10, 0, 6, 0, 0);
    put(1, 0, 0, 0, 2'b10, 0, 6, 0, 0);
    chk("sat_c.cnt2", 32'(cnt2), 32'd3);
    put(1, 0, 0, 0, 2'b10, 0, 6, 0, 0);
    chk("sat_d.stall2", 32'(stv(2)), 32'd0);
    idle();
    chk("sat.cnt0", 32'(cnt0), 32'd4);
    chk("sat.cnt2", 32'(cnt2), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
